cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_if.sv | 40 ++++
 rtl/cpu_sequencer.sv | 117 +++++++++++
 tb/tb_cpu_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Signal bundle between the multi-cycle instruction sequencer and its
// control unit, execute stage and instruction/data memories.
interface cpu_sequencer_if;
  logic        start;
  logic        halt_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_ready;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        pcsrc;
  logic [63:0] branch_addr;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        imem_req;
  logic        id_en;
  logic        ex_en;
  logic        dmem_req;
  logic        wb_en;
  logic        reg_wr_en;
  logic [2:0]  state;
  logic        busy;
  logic [31:0] instr_count;
  logic        err;

  modport master (
    input  start, halt_req, imem_ready, imem_rdata, dmem_ready,
           mem_read, mem_write, reg_write, pcsrc, branch_addr,
    output pc, instr, imem_req, id_en, ex_en, dmem_req, wb_en,
           reg_wr_en, state, busy, instr_count, err
  );

  modport slave (
    output start, halt_req, imem_ready, imem_rdata, dmem_ready,
           mem_read, mem_write, reg_write, pcsrc, branch_addr,
    input  pc, instr, imem_req, id_en, ex_en, dmem_req, wb_en,
           reg_wr_en, state, busy, instr_count, err
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with PC,
// retired-instruction counter and memory-wait timeout.
module cpu_sequencer #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MEM_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  cpu_sequencer_if.master bus
);
  localparam int               CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t           state_q, state_d, boundary;
  logic [63:0]      pc_q;
  logic [31:0]      instr_q;
  logic [31:0]      count_q;
  logic [CNT_W-1:0] wait_q;
  logic             load_q;
  logic             instr_ld, pc_ld, retire, wait_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Every move toward FETCH is an instruction boundary where a halt may divert it
  assign boundary = bus.halt_req ? S_HALT : S_FETCH;

  always_comb begin
    state_d  = state_q;
    instr_ld = 1'b0;
    pc_ld    = 1'b0;
    retire   = 1'b0;
    wait_inc = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) state_d = boundary;
      S_FETCH: begin
        if (bus.imem_ready) begin
          instr_ld = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_q == LAST_WAIT) state_d = S_ERROR;
        else wait_inc = 1'b1;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        pc_ld = 1'b1;
        if (bus.mem_read || bus.mem_write) state_d = S_MEM;
        else if (bus.reg_write)            state_d = S_WB;
        else begin
          retire  = 1'b1;
          state_d = boundary;
        end
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (load_q) state_d = S_WB;
          else begin
            retire  = 1'b1;
            state_d = boundary;
          end
        end else if (wait_q == LAST_WAIT) state_d = S_ERROR;
        else wait_inc = 1'b1;
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = boundary;
      end
      S_HALT, S_ERROR: if (!bus.start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load wins over store when both flags are set; the kind is frozen at EXEC exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      wait_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      if (instr_ld) instr_q <= bus.imem_rdata;
      if (pc_ld) begin
        pc_q   <= bus.pcsrc ? bus.branch_addr : pc_q + 64'd4;
        load_q <= bus.mem_read;
      end
      if (retire) count_q <= count_q + 32'd1;
      if (state_d != state_q) wait_q <= '0;
      else if (wait_inc)      wait_q <= wait_q + CNT_W'(1);
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_count = count_q;
  assign bus.state       = state_q;
  assign bus.imem_req    = (state_q == S_FETCH);
  assign bus.id_en       = (state_q == S_DECODE);
  assign bus.ex_en       = (state_q == S_EXEC);
  assign bus.dmem_req    = (state_q == S_MEM);
  assign bus.wb_en       = (state_q == S_WB);
  assign bus.reg_wr_en   = (state_q == S_WB) && (instr_q[4:0] != 5'd31);
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);
  assign bus.err         = (state_q == S_ERROR);
endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a per-instruction reference model queues
// expected retirements/errors; a monitor matches them at instruction boundaries.
module tb_cpu_sequencer;
  localparam logic [63:0] RST_PC  = 64'h0;
  localparam int          TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_sequencer_if bus ();
  cpu_sequencer #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0]  st;
    logic [63:0] pc;
    logic [31:0] cnt;
    logic [31:0] ins;
    int nf, nd, ne, nm, nw, nr;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] pc_m;
  logic [31:0] cnt_m;
  logic [31:0] ins_m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // HALT/ERROR -> IDLE on start=0, then restart into FETCH
  task automatic resume();
    bus.halt_req = 1'b0;
    bus.start    = 1'b0;
    step();
    chk("exit_to_idle", bus.state, 3'd0);
    bus.start = 1'b1;
    step();
    chk("restart_fetch", bus.state, 3'd1);
  endtask

  task automatic do_instr(input logic [4:0] rd, input bit mr, input bit mw, input bit rw,
                          input bit pcs, input logic [63:0] baddr, input int ilat,
                          input int dlat, input bit hreq);
    exp_t e;
    logic [31:0] w;
    w = $urandom;
    w[4:0] = rd;
    pc_m  = pcs ? baddr : pc_m + 64'd4;
    cnt_m = cnt_m + 32'd1;
    ins_m = w;
    e.st  = hreq ? 3'd6 : 3'd1;
    e.pc  = pc_m;
    e.cnt = cnt_m;
    e.ins = w;
    e.nf  = ilat + 1;
    e.nd  = 1;
    e.ne  = 1;
    e.nm  = (mr || mw) ? dlat + 1 : 0;
    e.nw  = (mr || (!mw && rw)) ? 1 : 0;
    e.nr  = (e.nw == 1 && rd != 5'd31) ? 1 : 0;
    q.push_back(e);

    bus.mem_read    = mr;
    bus.mem_write   = mw;
    bus.reg_write   = rw;
    bus.pcsrc       = pcs;
    bus.branch_addr = baddr;
    bus.halt_req    = hreq;
    repeat (ilat) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = ~w;
      step();
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = w;
    step();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = $urandom;
    step();
    step();
    if (mr || mw) begin
      repeat (dlat) begin
        bus.dmem_ready = 1'b0;
        step();
      end
      bus.dmem_ready = 1'b1;
      step();
      bus.dmem_ready = 1'b0;
      if (mr) step();
    end else if (rw) step();
    bus.halt_req = 1'b0;
    if (hreq) resume();
  endtask

  task automatic fetch_timeout();
    exp_t e;
    e.st = 3'd7; e.pc = pc_m; e.cnt = cnt_m; e.ins = ins_m;
    e.nf = TIMEOUT; e.nd = 0; e.ne = 0; e.nm = 0; e.nw = 0; e.nr = 0;
    q.push_back(e);
    bus.imem_ready = 1'b0;
    repeat (TIMEOUT) step();
    resume();
  endtask

  task automatic mem_timeout();
    exp_t e;
    logic [31:0] w;
    w     = $urandom;
    pc_m  = pc_m + 64'd4;
    ins_m = w;
    e.st = 3'd7; e.pc = pc_m; e.cnt = cnt_m; e.ins = w;
    e.nf = 1; e.nd = 1; e.ne = 1; e.nm = TIMEOUT; e.nw = 0; e.nr = 0;
    q.push_back(e);
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.reg_write = 1'b1; bus.pcsrc = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = w;
    step();
    bus.imem_ready = 1'b0;
    step();
    step();
    bus.dmem_ready = 1'b0;
    repeat (TIMEOUT) step();
    resume();
  endtask

  // Monitor: per-cycle output decode plus boundary-time scoreboard matching
  initial begin : monitor
    logic [2:0] s, prev;
    int nf, nd, ne, nm, nw, nr;
    exp_t e;
    prev = 3'd0;
    nf = 0; nd = 0; ne = 0; nm = 0; nw = 0; nr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 3'd0;
        nf = 0; nd = 0; ne = 0; nm = 0; nw = 0; nr = 0;
        continue;
      end
      s = bus.state;
      chk("stage_decode",
          {bus.imem_req, bus.id_en, bus.ex_en, bus.dmem_req, bus.wb_en, bus.busy, bus.err},
          {s == 3'd1, s == 3'd2, s == 3'd3, s == 3'd4, s == 3'd5,
           (s >= 3'd1 && s <= 3'd5), s == 3'd7});
      if (((s == 3'd1 || s == 3'd6) && (prev == 3'd3 || prev == 3'd4 || prev == 3'd5)) ||
          (s == 3'd7 && (prev == 3'd1 || prev == 3'd4))) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_boundary: state=%0d prev=%0d, no instruction pending", s, prev);
        end else begin
          e = q.pop_front();
          chk("end_state", s, e.st);
          chk("pc", bus.pc, e.pc);
          chk("instr_count", bus.instr_count, e.cnt);
          chk("instr", bus.instr, e.ins);
          chk("fetch_cycles", nf, e.nf);
          chk("decode_cycles", nd, e.nd);
          chk("exec_cycles", ne, e.ne);
          chk("mem_cycles", nm, e.nm);
          chk("wb_cycles", nw, e.nw);
          chk("reg_wr_cycles", nr, e.nr);
        end
        nf = 0; nd = 0; ne = 0; nm = 0; nw = 0; nr = 0;
      end
      if (s >= 3'd1 && s <= 3'd5) begin
        nf += (s == 3'd1) ? 1 : 0;
        nd += (s == 3'd2) ? 1 : 0;
        ne += (s == 3'd3) ? 1 : 0;
        nm += (s == 3'd4) ? 1 : 0;
        nw += (s == 3'd5) ? 1 : 0;
        nr += bus.reg_wr_en ? 1 : 0;
      end else begin
        nf = 0; nd = 0; ne = 0; nm = 0; nw = 0; nr = 0;
      end
      prev = s;
    end
  end

  initial begin : driver
    logic [4:0]  rd;
    logic [63:0] ba;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.halt_req = 1'b0; bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    bus.dmem_ready = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.reg_write = 1'b0; bus.pcsrc = 1'b0; bus.branch_addr = '0;
    pc_m = RST_PC; cnt_m = '0; ins_m = '0;
    #1;
    chk("rst_state", bus.state, 3'd0);
    chk("rst_pc", bus.pc, RST_PC);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_count", bus.instr_count, 32'd0);
    chk("rst_outputs",
        {bus.imem_req, bus.id_en, bus.ex_en, bus.dmem_req, bus.wb_en, bus.reg_wr_en, bus.busy, bus.err},
        8'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_without_start", bus.state, 3'd0);
    bus.halt_req = 1'b1;
    bus.start    = 1'b1;
    step();
    chk("halt_from_idle", bus.state, 3'd6);
    resume();

    do_instr(5'd3,  0, 0, 1, 0, 64'h0, 0, 0, 0);   // ADD rd=3
    do_instr(5'd7,  1, 0, 1, 0, 64'h0, 0, 3, 0);   // LDUR, 3 wait cycles
    do_instr(5'd31, 0, 0, 1, 0, 64'h0, 1, 0, 0);   // ADD to XZR
    do_instr(5'd1,  0, 0, 0, 1, 64'h40, 0, 0, 0);  // taken branch
    do_instr(5'd2,  0, 1, 1, 0, 64'h0, 0, 2, 0);   // STUR
    do_instr(5'd4,  1, 1, 1, 0, 64'h0, 0, 0, 0);   // load+store flags: load
    do_instr(5'd5,  0, 0, 1, 0, 64'h0, TIMEOUT - 1, 0, 0);
    do_instr(5'd6,  1, 0, 0, 0, 64'h0, 0, TIMEOUT - 1, 0);
    do_instr(5'd8,  0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
    do_instr(5'd9,  0, 0, 0, 0, 64'h0, 0, 0, 0);   // pc wraps to 0
    fetch_timeout();
    mem_timeout();
    do_instr(5'd10, 0, 0, 0, 0, 64'h0, 0, 0, 1);   // halt seen at EXEC exit
    do_instr(5'd11, 1, 0, 1, 0, 64'h0, 1, 1, 1);   // halt seen after WB

    for (int i = 0; i < 40; i++) begin
      rd = 5'($urandom);
      if ($urandom_range(0, 3) == 0) rd = 5'd31;
      ba = {$urandom, $urandom} & ~64'h3;
      do_instr(rd, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, ba,
               $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 7) == 0);
    end
    step();
    step();
    chk("scoreboard_drained", q.size(), 0);

    // Reset in the middle of a MEM wait
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.reg_write = 1'b1; bus.pcsrc = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEE3;
    step();
    bus.imem_ready = 1'b0;
    step();
    step();
    bus.dmem_ready = 1'b0;
    step();
    step();
    chk("in_mem_before_reset", bus.state, 3'd4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", bus.state, 3'd0);
    chk("async_rst_pc", bus.pc, RST_PC);
    chk("async_rst_count", bus.instr_count, 32'd0);
    chk("async_rst_instr", bus.instr, 32'd0);
    chk("async_rst_outputs",
        {bus.imem_req, bus.id_en, bus.ex_en, bus.dmem_req, bus.wb_en, bus.reg_wr_en, bus.busy, bus.err},
        8'd0);
    bus.start = 1'b0;
    bus.mem_read = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("idle_after_reset", bus.state, 3'd0);
    bus.start = 1'b1;
    step();
    chk("fetch_after_reset_start", bus.state, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
